// File: rtl/comp_serial.sv
// comp_serial: multi-cycle MSB-first magnitude comparator.
// Compares two WIDTH-bit operands DIGIT bits per clock, signed or unsigned.
// It stops at the first differing slice and reports a one-hot EQ/GT/LT result.
//
// Handshake: i_start is accepted only in IDLE or DONE. The accepting edge
// captures i_a, i_b and i_signed_mode, clears the result flags and moves to
// CMP. While o_busy=1 (CMP), i_start is ignored. o_done pulses high for
// exactly one cycle in DONE. From that cycle, exactly one of o_eq/o_gt/o_lt
// stays high until the next accepting edge. If i_start is high during DONE,
// a new compare starts on the next edge without passing through IDLE.
module comp_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_signed_mode,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_eq,
   output logic             o_gt,
   output logic             o_lt,
   output logic [1:0]       o_state
);

   localparam int N     = WIDTH / DIGIT;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int SH_W  = $clog2(WIDTH) + 1;

   // Flipping the sign bit of both operands maps two's-complement order onto
   // unsigned order, so a single unsigned slice compare serves both modes.
   localparam logic [WIDTH-1:0] MSB_MASK = (WIDTH)'(1) << (WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             r_eq;
   logic             r_gt;
   logic             r_lt;
   logic             w_eq_nxt;
   logic             w_gt_nxt;
   logic             w_lt_nxt;

   logic [WIDTH-1:0] w_flip;
   logic [SH_W-1:0]  w_base;
   logic [DIGIT-1:0] w_slice_a;
   logic [DIGIT-1:0] w_slice_b;
   logic             w_slice_gt;
   logic             w_slice_lt;
   logic             w_accept;

   // Operand pre-conditioning and the slice currently under comparison.
   assign w_flip     = i_signed_mode ? MSB_MASK : '0;
   assign w_base     = SH_W'(r_idx) * SH_W'(DIGIT);
   assign w_slice_a  = r_a[w_base +: DIGIT];
   assign w_slice_b  = r_b[w_base +: DIGIT];
   assign w_slice_gt = (w_slice_a > w_slice_b);
   assign w_slice_lt = (w_slice_a < w_slice_b);
   assign w_accept   = i_start && (r_state != ST_CMP);

   // Next-state and datapath update: capture on accept, walk slices in CMP.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_idx_nxt   = r_idx;
      w_eq_nxt    = r_eq;
      w_gt_nxt    = r_gt;
      w_lt_nxt    = r_lt;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               w_state_nxt = ST_CMP;
               w_a_nxt     = i_a ^ w_flip;
               w_b_nxt     = i_b ^ w_flip;
               w_idx_nxt   = IDX_TOP;
               w_eq_nxt    = 1'b0;
               w_gt_nxt    = 1'b0;
               w_lt_nxt    = 1'b0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CMP: begin
            if (w_slice_gt) begin
               w_gt_nxt    = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (w_slice_lt) begin
               w_lt_nxt    = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (r_idx == '0) begin
               w_eq_nxt    = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_idx_nxt   = r_idx - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, operand, index and result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_eq    <= 1'b0;
         r_gt    <= 1'b0;
         r_lt    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_idx   <= w_idx_nxt;
         r_eq    <= w_eq_nxt;
         r_gt    <= w_gt_nxt;
         r_lt    <= w_lt_nxt;
      end
   end

   assign o_busy  = (r_state == ST_CMP);
   assign o_done  = (r_state == ST_DONE);
   assign o_eq    = r_eq;
   assign o_gt    = r_gt;
   assign o_lt    = r_lt;
   assign o_state = r_state;

endmodule

// File: tb/tb_comp_serial.sv
// tb_comp_serial: vector table, randomized model compare and corner sequences.
module tb_comp_serial;

   localparam int WIDTH = 32;
   localparam int DIGIT = 2;
   localparam int N     = WIDTH / DIGIT;

   localparam logic [2:0] R_EQ = 3'b100;
   localparam logic [2:0] R_GT = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sm;
      logic [2:0]  res;
      int          lat;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (N=16) ----------------
   logic        i_start;
   logic        i_sm;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_busy;
   logic        o_done;
   logic        o_eq;
   logic        o_gt;
   logic        o_lt;
   logic [1:0]  o_state;

   comp_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (i_start),
      .i_signed_mode (i_sm),
      .i_a           (i_a),
      .i_b           (i_b),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_eq          (o_eq),
      .o_gt          (o_gt),
      .o_lt          (o_lt),
      .o_state       (o_state)
   );

   // ---------------- DUT (DIGIT == WIDTH, N=1) ----------------
   logic       s_start;
   logic       s_sm;
   logic [7:0] s_a;
   logic [7:0] s_b;
   logic       s_busy;
   logic       s_done;
   logic       s_eq;
   logic       s_gt;
   logic       s_lt;
   logic [1:0] s_state;

   comp_serial #(.WIDTH(8), .DIGIT(8)) u_dut1 (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (s_start),
      .i_signed_mode (s_sm),
      .i_a           (s_a),
      .i_b           (s_b),
      .o_busy        (s_busy),
      .o_done        (s_done),
      .o_eq          (s_eq),
      .o_gt          (s_gt),
      .o_lt          (s_lt),
      .o_state       (s_state)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_errors = 0;
   logic [2:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: result by ordinary signed/unsigned comparison; latency is
   // the number of DIGIT-wide slices from the top down to and including the
   // one holding the highest differing bit (all N when equal).
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        output logic [2:0] res, output int lat);
      logic [31:0] x;
      int          hi;
      if (a == b)
         res = R_EQ;
      else if (sm ? ($signed(a) > $signed(b)) : (a > b))
         res = R_GT;
      else
         res = R_LT;
      x  = a ^ b;
      hi = -1;
      for (int i = 31; i >= 0; i--) begin
         if (x[i] && hi < 0) hi = i;
      end
      lat = (hi < 0) ? N : (N - hi / DIGIT);
   endtask

   // ---------------- driver ----------------
   // Starts from IDLE or DONE; returns one negedge after the done cycle.
   task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic sm,
                          input logic [2:0] exp_res, input int exp_lat);
      int         edges;
      logic [2:0] exp_r;
      exp_q.push_back(exp_res);
      @(negedge clk);
      i_start = 1'b1;
      i_a     = a;
      i_b     = b;
      i_sm    = sm;
      @(negedge clk);
      i_start = 1'b0;
      i_a     = $urandom;
      i_b     = $urandom;
      i_sm    = 1'($urandom_range(0, 1));
      chk("busy_after_accept", 64'(o_busy), 64'(1));
      chk("res_clear_after_accept", 64'({o_eq, o_gt, o_lt}), 64'(0));
      edges = 0;
      while (o_done !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      exp_r = exp_q.pop_front();
      chk("latency", 64'(edges), 64'(exp_lat));
      chk("result", 64'({o_eq, o_gt, o_lt}), 64'(exp_r));
      chk("busy_in_done", 64'(o_busy), 64'(0));
      @(negedge clk);
      chk("done_one_cycle", 64'(o_done), 64'(0));
      chk("result_held", 64'({o_eq, o_gt, o_lt}), 64'(exp_r));
   endtask

   // ---------------- stimulus ----------------
   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t        vecs[6];
      logic [2:0]  m_res;
      int          m_lat;
      int          edges;
      int          n_done;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rsm;

      vecs[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, R_GT, 1};
      vecs[1] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, R_LT, 1};
      vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b0, R_EQ, 16};
      vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b1, R_EQ, 16};
      vecs[4] = '{32'h0000_0001, 32'h0000_0002, 1'b0, R_LT, 16};
      vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, R_LT, 1};

      rst_n   = 1'b0;
      i_start = 1'b0;
      i_sm    = 1'b0;
      i_a     = '0;
      i_b     = '0;
      s_start = 1'b0;
      s_sm    = 1'b0;
      s_a     = '0;
      s_b     = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({o_busy, o_done, o_eq, o_gt, o_lt}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 64'({o_busy, o_done, o_eq, o_gt, o_lt}), 64'(0));

      // Directed vector table.
      for (int i = 0; i < 6; i++) begin
         run_cmp(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res, vecs[i].lat);
      end

      // Randomized compares against the reference model.
      for (int i = 0; i < 40; i++) begin
         ra  = $urandom;
         rsm = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       rb = $urandom;
            1:       rb = ra;
            default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
         endcase
         model(ra, rb, rsm, m_res, m_lat);
         run_cmp(ra, rb, rsm, m_res, m_lat);
      end

      // Start pulsed during CMP is ignored.
      @(negedge clk);
      i_start = 1'b1; i_a = 32'd5; i_b = 32'd5; i_sm = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      edges = 0;
      while (o_done !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
         if (edges == 2) begin
            i_start = 1'b1; i_a = 32'd9; i_b = 32'd1;
         end else if (edges == 3) begin
            i_start = 1'b0;
         end
      end
      chk("ignore_start_latency", 64'(edges), 64'(16));
      chk("ignore_start_result", 64'({o_eq, o_gt, o_lt}), 64'(R_EQ));
      @(negedge clk);
      chk("ignore_start_idle", 64'({o_busy, o_done}), 64'(0));

      // Reset mid-compare: outputs drop at once and no done follows.
      i_start = 1'b1; i_a = 32'd5; i_b = 32'd5;
      @(negedge clk);
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 64'({o_busy, o_done, o_eq, o_gt, o_lt}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_done === 1'b1 || o_busy === 1'b1) n_done++;
      end
      chk("no_done_after_reset", 64'(n_done), 64'(0));

      // Back-to-back: start held high through DONE.
      i_start = 1'b1; i_a = 32'hA; i_b = 32'hA; i_sm = 1'b0;
      @(negedge clk);
      i_a = 32'd3; i_b = 32'd7;
      edges = 0;
      while (o_done !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      chk("b2b_first_latency", 64'(edges), 64'(16));
      chk("b2b_first_result", 64'({o_eq, o_gt, o_lt}), 64'(R_EQ));
      @(negedge clk);
      i_start = 1'b0;
      chk("b2b_no_idle_busy", 64'({o_busy, o_done}), 64'(2'b10));
      chk("b2b_res_cleared", 64'({o_eq, o_gt, o_lt}), 64'(0));
      model(32'd3, 32'd7, 1'b0, m_res, m_lat);
      edges = 0;
      while (o_done !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      chk("b2b_second_latency", 64'(edges), 64'(m_lat));
      chk("b2b_second_result", 64'({o_eq, o_gt, o_lt}), 64'(m_res));
      @(negedge clk);

      // Single-slice instance: every compare completes in one edge.
      for (int i = 0; i < 10; i++) begin
         s_a  = 8'($urandom);
         s_b  = (i % 3 == 0) ? s_a : 8'($urandom);
         s_sm = 1'($urandom_range(0, 1));
         if (s_a == s_b)
            m_res = R_EQ;
         else if (s_sm ? ($signed(s_a) > $signed(s_b)) : (s_a > s_b))
            m_res = R_GT;
         else
            m_res = R_LT;
         s_start = 1'b1;
         @(negedge clk);
         s_start = 1'b0;
         chk("n1_busy", 64'({s_busy, s_done}), 64'(2'b10));
         @(negedge clk);
         chk("n1_done", 64'(s_done), 64'(1));
         chk("n1_result", 64'({s_eq, s_gt, s_lt}), 64'(m_res));
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
